// File: rtl/matrix_stream_reader_pkg.sv
// Shared definitions for the transformer matrix path: element and matrix
// geometry, the stream reader state encoding, the beat payload and the
// address helper used for row-major and transposed reads.
package transformer_pkg;

  localparam int DATA_W      = 16;
  localparam int DIM         = 64;
  localparam int LOG2_DIM    = $clog2(DIM);
  localparam int ADDR_W      = 2 * LOG2_DIM;
  localparam int MAT_ENTRIES = DIM * DIM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } reader_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [LOG2_DIM-1:0] row;
    logic [LOG2_DIM-1:0] col;
    logic                last_col;
    logic                last;
  } beat_t;

  // Maps the linear issue index to an SRAM address; transposed order swaps
  // the row and column halves so the stream walks the matrix by columns.
  function automatic logic [ADDR_W-1:0] reader_addr(input logic [ADDR_W-1:0] idx,
                                                   input logic              xpose);
    logic [LOG2_DIM-1:0] r;
    logic [LOG2_DIM-1:0] c;
    r = idx[ADDR_W-1:LOG2_DIM];
    c = idx[LOG2_DIM-1:0];
    return xpose ? {c, r} : {r, c};
  endfunction

endpackage

// File: rtl/matrix_stream_reader_if.sv
// Bus bundle of the stream reader: the SRAM read port toward the shared
// matrix memory and the valid/ready element stream toward the datapath.
// The master side is the reader itself.
interface matrix_stream_reader_if import transformer_pkg::*; ();

  logic                mem_re;
  logic [ADDR_W-1:0]   mem_raddr;
  logic [DATA_W-1:0]   mem_rdata;
  logic                m_valid;
  logic                m_ready;
  logic [DATA_W-1:0]   m_data;
  logic [LOG2_DIM-1:0] m_row;
  logic [LOG2_DIM-1:0] m_col;
  logic                m_last_col;
  logic                m_last;

  modport master (
    output mem_re, mem_raddr,
    input  mem_rdata,
    output m_valid,
    input  m_ready,
    output m_data, m_row, m_col, m_last_col, m_last
  );

  modport slave (
    input  mem_re, mem_raddr,
    output mem_rdata,
    input  m_valid,
    output m_ready,
    input  m_data, m_row, m_col, m_last_col, m_last
  );

endinterface

// File: rtl/matrix_stream_reader_fifo.sv
// Two-entry synchronous FIFO used as the skid buffer between SRAM read
// returns and the output stream. Pops on an empty buffer are ignored; a push
// into a full buffer is accepted only when a pop frees a slot on the same edge.
module stream_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] slot_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign empty   = (count_q == 2'd0);
  assign full    = (count_q == 2'd2);
  assign count   = count_q;
  assign dout    = slot_q[rd_ptr_q];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) wr_ptr_q <= !wr_ptr_q;
      if (do_pop)  rd_ptr_q <= !rd_ptr_q;
      if (do_push && !do_pop)      count_q <= count_q + 2'd1;
      else if (do_pop && !do_push) count_q <= count_q - 2'd1;
    end
  end

  // Payload storage; when full, the slot being written is the one popped on this edge
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
    end else if (do_push) begin
      slot_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/matrix_stream_reader.sv
// Streams the 64x64 matrix from the shared SRAM to the transformer datapath,
// one element per beat, in row-major or transposed order. Reads are issued
// only when the two-entry buffer plus the single in-flight read can absorb the
// result, so backpressure never drops or duplicates an element.
module matrix_stream_reader import transformer_pkg::*; (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    start,
  input  logic                    transpose,
  matrix_stream_reader_if.master  bus,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAT_ENTRIES - 1);

  reader_state_t       state_q;
  reader_state_t       state_d;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic [ADDR_W-1:0]   issue_addr;
  logic                xpose_q;
  logic                inflight_q;
  logic [LOG2_DIM-1:0] issue_row;
  logic [LOG2_DIM-1:0] issue_col;
  logic [LOG2_DIM-1:0] fl_row_q;
  logic [LOG2_DIM-1:0] fl_col_q;
  logic                fl_last_col_q;
  logic                fl_last_q;
  beat_t               push_beat;
  beat_t               head_beat;
  beat_t               out_beat;
  logic                push;
  logic                pop;
  logic                issue;
  logic                fifo_full;
  logic                fifo_empty;
  logic [1:0]          fifo_count;
  logic [2:0]          projected;

  assign issue_row  = idx_q[ADDR_W-1:LOG2_DIM];
  assign issue_col  = idx_q[LOG2_DIM-1:0];
  assign issue_addr = reader_addr(idx_q, xpose_q);

  assign pop       = !fifo_empty && bus.m_ready;
  assign projected = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue     = (state_q == RUN) && (projected < 3'd2);

  assign bus.mem_re    = issue;
  assign bus.mem_raddr = issue ? issue_addr : raddr_q;

  assign push      = inflight_q;
  assign push_beat = '{data:     bus.mem_rdata,
                       row:      fl_row_q,
                       col:      fl_col_q,
                       last_col: fl_last_col_q,
                       last:     fl_last_q};

  assign out_beat       = fifo_empty ? '0 : head_beat;
  assign bus.m_valid    = !fifo_empty;
  assign bus.m_data     = out_beat.data;
  assign bus.m_row      = out_beat.row;
  assign bus.m_col      = out_beat.col;
  assign bus.m_last_col = out_beat.last_col;
  assign bus.m_last     = out_beat.last;

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

  stream_fifo2 #(
    .W ($bits(beat_t))
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .pop   (pop),
    .din   (push_beat),
    .dout  (head_beat),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // State register
  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: start is only honoured in IDLE, DONE lasts a single cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && (idx_q == LAST_IDX)) state_d = DRAIN;
      DRAIN:   if (pop && out_beat.last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Issue counter and latched order; the counter stops at the last element instead of wrapping
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idx_q   <= '0;
      xpose_q <= 1'b0;
    end else if ((state_q == IDLE) && start) begin
      idx_q   <= '0;
      xpose_q <= transpose;
    end else if (issue && (idx_q != LAST_IDX)) begin
      idx_q <= idx_q + ADDR_W'(1);
    end
  end

  // In-flight read tracking; reset clears the flag so a late SRAM return is never buffered
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      inflight_q    <= 1'b0;
      fl_row_q      <= '0;
      fl_col_q      <= '0;
      fl_last_col_q <= 1'b0;
      fl_last_q     <= 1'b0;
      raddr_q       <= '0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        fl_row_q      <= issue_row;
        fl_col_q      <= issue_col;
        fl_last_col_q <= (issue_col == LOG2_DIM'(DIM - 1));
        fl_last_q     <= (idx_q == LAST_IDX);
        raddr_q       <= issue_addr;
      end
    end
  end

  // Buffer overflow guard: the issue throttle must make this impossible
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) assert (!(fifo_full && push && !pop));
  end

endmodule

// File: tb/tb_matrix_stream_reader.sv
// Directed bench for matrix_stream_reader: SRAM model holding mem[a]=a, a
// stream runner with an independent occupancy model, and a linear sequence
// of scenarios covering order, backpressure, restart and abort behaviour.
module tb_matrix_stream_reader;
  import transformer_pkg::*;

  localparam int CYCLE_LIMIT = 30000;

  logic sys_clk = 1'b0;
  logic sys_rst;
  logic start;
  logic transpose;
  logic m_ready_drv;
  logic busy;
  logic done;

  logic [DATA_W-1:0] sram [MAT_ENTRIES];
  logic [DATA_W-1:0] rdata_q;

  int n_asserts = 0;
  int n_fails   = 0;

  int res_beats, res_data_errs, res_flag_errs, res_stab_errs, res_valid_errs;
  int res_max_occ, res_first_cycle, res_last_cycle, res_done_cycle, res_done_count;
  int res_re_total, res_re_stall, res_re1, res_addr1, res_addr2, res_stall_addr;
  int res_beat0, res_beat1, res_beat64, res_timeout;
  int idle_errs;

  matrix_stream_reader_if bus ();

  assign bus.m_ready   = m_ready_drv;
  assign bus.mem_rdata = rdata_q;

  matrix_stream_reader dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .transpose (transpose),
    .bus       (bus),
    .busy      (busy),
    .done      (done)
  );

  // Free-running system clock
  always #5 sys_clk = ~sys_clk;

  // SRAM model with one-cycle read latency; non-read cycles return a marker value
  always @(posedge sys_clk) begin
    if (bus.mem_re === 1'b1) rdata_q <= sram[bus.mem_raddr];
    else                     rdata_q <= 16'hDEAD;
  end

  task automatic applyStimulus(input logic st, input logic tr, input logic rdy, input logic rst);
    start       = st;
    transpose   = tr;
    m_ready_drv = rdy;
    sys_rst     = rst;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_asserts++;
    assert (observed === expected)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Pulses start, then drives m_ready per cycle and scores every beat against
  // the expected element order, flag values, stability and buffer occupancy.
  task automatic runStream(input bit xp, input int ready_pct, input int stall_len,
                           input int restart_beat, input int stop_beat);
    int re_cm1, re_cm2, pops_before, occ, stall_end, k;
    bit pulsed, prev_hold, hs, rdy, st, tr;
    logic [DATA_W-1:0]   p_data, exp_data;
    logic [LOG2_DIM-1:0] p_row, p_col, er, ec;
    logic                p_lc, p_l;
    res_beats = 0; res_data_errs = 0; res_flag_errs = 0; res_stab_errs = 0;
    res_valid_errs = 0; res_max_occ = 0; res_first_cycle = -1; res_last_cycle = -1;
    res_done_cycle = -1; res_done_count = 0; res_re_total = 0; res_re_stall = 0;
    res_re1 = 0; res_addr1 = -1; res_addr2 = -1; res_stall_addr = -1;
    res_beat0 = -1; res_beat1 = -1; res_beat64 = -1; res_timeout = 1;
    re_cm1 = 0; re_cm2 = 0; pops_before = 0; pulsed = 0; prev_hold = 0;
    p_data = '0; p_row = '0; p_col = '0; p_lc = 1'b0; p_l = 1'b0;
    stall_end = (stall_len > 0) ? CYCLE_LIMIT + 1 : 0;
    @(negedge sys_clk);
    applyStimulus(1'b1, xp, 1'b0, 1'b0);
    for (int cyc = 1; cyc <= CYCLE_LIMIT; cyc++) begin
      @(negedge sys_clk);
      st = 1'b0;
      tr = xp;
      if (restart_beat >= 0 && !pulsed && res_beats >= restart_beat) begin
        st = 1'b1;
        tr = !xp;
        pulsed = 1'b1;
      end
      if (cyc < stall_end)      rdy = 1'b0;
      else if (ready_pct >= 100) rdy = 1'b1;
      else                      rdy = ($urandom_range(0, 99) < ready_pct);
      applyStimulus(st, tr, rdy, 1'b0);
      #1;
      occ = re_cm2 - pops_before;
      if (occ > res_max_occ) res_max_occ = occ;
      if (bus.m_valid !== (occ > 0)) res_valid_errs++;
      if (prev_hold && (bus.m_valid !== 1'b1 || bus.m_data !== p_data || bus.m_row !== p_row ||
                        bus.m_col !== p_col || bus.m_last_col !== p_lc || bus.m_last !== p_l))
        res_stab_errs++;
      if (bus.m_valid === 1'b1 && res_first_cycle < 0) begin
        res_first_cycle = cyc;
        if (stall_len > 0) stall_end = cyc + stall_len;
      end
      if (cyc == 1) begin
        res_re1   = int'(bus.mem_re === 1'b1);
        res_addr1 = int'(bus.mem_raddr);
      end
      if (cyc == 2) res_addr2 = int'(bus.mem_raddr);
      if (bus.mem_re === 1'b1) begin
        res_re_total++;
        if (cyc < stall_end) res_re_stall++;
      end
      if (cyc < stall_end && bus.m_valid === 1'b1 && bus.m_data !== '0) res_data_errs++;
      if (stall_len > 0 && res_first_cycle > 0 && cyc == res_first_cycle + 50)
        res_stall_addr = int'(bus.mem_raddr);
      hs = (bus.m_valid === 1'b1) && rdy;
      if (hs) begin
        k  = res_beats;
        er = LOG2_DIM'(k / DIM);
        ec = LOG2_DIM'(k % DIM);
        exp_data = xp ? DATA_W'(int'(ec) * DIM + int'(er)) : DATA_W'(k);
        if (bus.m_data !== exp_data || bus.m_row !== er || bus.m_col !== ec) res_data_errs++;
        if (bus.m_last_col !== (ec == LOG2_DIM'(DIM - 1)) || bus.m_last !== (k == MAT_ENTRIES - 1))
          res_flag_errs++;
        if (k == 0)  res_beat0  = int'(bus.m_data);
        if (k == 1)  res_beat1  = int'(bus.m_data);
        if (k == 64) res_beat64 = int'(bus.m_data);
        if (k == MAT_ENTRIES - 1) res_last_cycle = cyc;
        res_beats++;
      end
      if (done === 1'b1) begin
        res_done_count++;
        res_done_cycle = cyc;
      end
      prev_hold = (bus.m_valid === 1'b1) && !rdy;
      p_data = bus.m_data; p_row = bus.m_row; p_col = bus.m_col;
      p_lc = bus.m_last_col; p_l = bus.m_last;
      pops_before += int'(hs);
      re_cm2 = re_cm1;
      re_cm1 += int'(bus.mem_re === 1'b1);
      if (stop_beat < MAT_ENTRIES && res_beats >= stop_beat) begin
        res_timeout = 0;
        break;
      end
      if (res_done_count > 0) begin
        res_timeout = 0;
        break;
      end
    end
  endtask

  initial begin
    for (int a = 0; a < MAT_ENTRIES; a++) sram[a] = DATA_W'(a);

    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(negedge sys_clk);
    #1;
    checkOutput("rst_m_valid", 32'(bus.m_valid), 0);
    checkOutput("rst_busy",    32'(busy), 0);
    checkOutput("rst_done",    32'(done), 0);
    checkOutput("rst_mem_re",  32'(bus.mem_re), 0);
    checkOutput("rst_raddr",   32'(bus.mem_raddr), 0);
    checkOutput("rst_m_data",  32'(bus.m_data), 0);
    checkOutput("rst_m_last",  32'(bus.m_last), 0);
    checkOutput("rst_state",   32'(dut.state_q), 32'(IDLE));
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Row-major, m_ready held high
    $display("[TB] row-major stream");
    runStream(1'b0, 100, 0, -1, MAT_ENTRIES);
    checkOutput("rm_timeout",    res_timeout, 0);
    checkOutput("rm_beats",      res_beats, 4096);
    checkOutput("rm_data_errs",  res_data_errs, 0);
    checkOutput("rm_flag_errs",  res_flag_errs, 0);
    checkOutput("rm_valid_errs", res_valid_errs, 0);
    checkOutput("rm_re_cycle1",  res_re1, 1);
    checkOutput("rm_addr_cyc1",  res_addr1, 0);
    checkOutput("rm_addr_cyc2",  res_addr2, 1);
    checkOutput("rm_first_beat", res_first_cycle, 3);
    checkOutput("rm_last_beat",  res_last_cycle, 4098);
    checkOutput("rm_done_cycle", res_done_cycle, 4099);
    checkOutput("rm_done_count", res_done_count, 1);
    checkOutput("rm_re_total",   res_re_total, 4096);
    @(negedge sys_clk);
    #1;
    checkOutput("rm_busy_after",  32'(busy), 0);
    checkOutput("rm_state_after", 32'(dut.state_q), 32'(IDLE));

    // Transposed order
    $display("[TB] transposed stream");
    runStream(1'b1, 100, 0, -1, MAT_ENTRIES);
    checkOutput("tr_beats",      res_beats, 4096);
    checkOutput("tr_data_errs",  res_data_errs, 0);
    checkOutput("tr_flag_errs",  res_flag_errs, 0);
    checkOutput("tr_addr_cyc2",  res_addr2, 64);
    checkOutput("tr_beat1",      res_beat1, 64);
    checkOutput("tr_beat64",     res_beat64, 1);
    checkOutput("tr_done_count", res_done_count, 1);

    // Random backpressure at 30% ready
    $display("[TB] random backpressure stream");
    runStream(1'b0, 30, 0, -1, MAT_ENTRIES);
    checkOutput("rnd_timeout",    res_timeout, 0);
    checkOutput("rnd_beats",      res_beats, 4096);
    checkOutput("rnd_data_errs",  res_data_errs, 0);
    checkOutput("rnd_flag_errs",  res_flag_errs, 0);
    checkOutput("rnd_stab_errs",  res_stab_errs, 0);
    checkOutput("rnd_valid_errs", res_valid_errs, 0);
    checkOutput("rnd_occ_le_2",   32'(res_max_occ <= 2), 1);
    checkOutput("rnd_done_count", res_done_count, 1);
    checkOutput("rnd_re_total",   res_re_total, 4096);

    // m_ready low for 100 cycles once the first beat is offered
    $display("[TB] stalled stream");
    runStream(1'b0, 100, 100, -1, MAT_ENTRIES);
    checkOutput("stall_first_beat", res_first_cycle, 3);
    checkOutput("stall_re_count",   res_re_stall, 2);
    checkOutput("stall_raddr_hold", res_stall_addr, 1);
    checkOutput("stall_data_errs",  res_data_errs, 0);
    checkOutput("stall_stab_errs",  res_stab_errs, 0);
    checkOutput("stall_beats",      res_beats, 4096);

    // Second start at beat 500 is ignored, even with transpose flipped
    $display("[TB] restart ignored mid-stream");
    runStream(1'b0, 100, 0, 500, MAT_ENTRIES);
    checkOutput("rs_beats",      res_beats, 4096);
    checkOutput("rs_data_errs",  res_data_errs, 0);
    checkOutput("rs_done_count", res_done_count, 1);
    checkOutput("rs_re_total",   res_re_total, 4096);
    runStream(1'b0, 100, 0, -1, MAT_ENTRIES);
    checkOutput("rs2_first_beat", res_first_cycle, 3);
    checkOutput("rs2_beat0",      res_beat0, 0);
    checkOutput("rs2_beats",      res_beats, 4096);
    checkOutput("rs2_data_errs",  res_data_errs, 0);

    // Reset at beat 1000 aborts the stream
    $display("[TB] reset mid-stream");
    runStream(1'b0, 100, 0, -1, 1000);
    checkOutput("ab_beats", res_beats, 1000);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge sys_clk);
    #1;
    checkOutput("ab_m_valid", 32'(bus.m_valid), 0);
    checkOutput("ab_busy",    32'(busy), 0);
    checkOutput("ab_mem_re",  32'(bus.mem_re), 0);
    checkOutput("ab_done",    32'(done), 0);
    checkOutput("ab_m_data",  32'(bus.m_data), 0);
    checkOutput("ab_state",   32'(dut.state_q), 32'(IDLE));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    idle_errs = 0;
    repeat (10) begin
      @(negedge sys_clk);
      #1;
      if (bus.m_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || bus.mem_re !== 1'b0)
        idle_errs++;
    end
    checkOutput("ab_quiet_after", idle_errs, 0);
    runStream(1'b0, 100, 0, -1, MAT_ENTRIES);
    checkOutput("ab2_first_beat", res_first_cycle, 3);
    checkOutput("ab2_beat0",      res_beat0, 0);
    checkOutput("ab2_beats",      res_beats, 4096);
    checkOutput("ab2_data_errs",  res_data_errs, 0);
    checkOutput("ab2_done_count", res_done_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
